// File: rtl/conv_accum_pkg.sv
// ============================================================================
// Module : conv_accum_pkg
// Shared CNN constants and window-accumulator state encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package conv_accum_pkg;

  localparam int c_taps_default  = 9;
  localparam int c_acc_w_default = 13;
  localparam int c_shift_default = 0;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/conv_accum_sat_shift.sv
// ============================================================================
// Module : sat_shift
// Right-shifts an ACC_W-bit unsigned sum and saturates it to an 8-bit pixel.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_shift #(
  parameter int ACC_W = 13,
  parameter int SHIFT = 0
) (
  input  logic [ACC_W-1:0] sum,
  output logic [7:0]       pix
);

  logic [ACC_W-1:0] w_shifted;

  always_comb begin
    w_shifted = sum >> SHIFT;
    pix       = (w_shifted > ACC_W'(255)) ? 8'hFF : w_shifted[7:0];
  end

endmodule

`default_nettype wire

// File: rtl/conv_accum.sv
// ============================================================================
// Module : conv_accum
// Sums TAPS products plus a per-window bias, then shifts/saturates to a pixel.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module conv_accum
  import conv_accum_pkg::*;
#(
  parameter int TAPS  = c_taps_default,
  parameter int ACC_W = c_acc_w_default,
  parameter int SHIFT = c_shift_default
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] bias,
  input  logic       clear,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  localparam int CNT_W = $clog2(TAPS);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_tap_cnt;
  logic [ACC_W-1:0] r_acc;
  logic [7:0]       r_out_data;

  logic             w_accept;
  logic             w_last;
  logic [ACC_W-1:0] w_sum;
  logic [7:0]       w_pix;

  // Outputs depend on registered state only.
  assign in_ready  = (r_state == ST_ACCUM);
  assign out_valid = (r_state == ST_HOLD);
  assign out_data  = r_out_data;
  assign busy      = (r_tap_cnt != '0) || (r_state == ST_HOLD);

  assign w_accept = in_valid && (r_state == ST_ACCUM) && !clear;
  assign w_last   = (r_tap_cnt == CNT_W'(TAPS - 1));
  assign w_sum    = ((r_tap_cnt == '0) ? ACC_W'(bias) : r_acc) + ACC_W'(in_data);

  sat_shift #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_sat_shift (
    .sum (w_sum),
    .pix (w_pix)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACCUM: if (w_accept && w_last) w_state_nxt = ST_HOLD;
      ST_HOLD:  if (clear || out_ready) w_state_nxt = ST_ACCUM;
      default:  w_state_nxt = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_ACCUM;
      r_tap_cnt  <= '0;
      r_acc      <= '0;
      r_out_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_ACCUM) begin
        if (clear) begin
          r_tap_cnt <= '0;
          r_acc     <= '0;
        end else if (w_accept) begin
          r_acc <= w_sum;
          if (w_last) begin
            r_tap_cnt  <= '0;
            r_out_data <= w_pix;
          end else begin
            r_tap_cnt <= r_tap_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_conv_accum.sv
// ============================================================================
// Module : tb_conv_accum
// Directed self-checking bench; SHIFT=0 and SHIFT=4 instances share stimulus.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_conv_accum;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic [7:0] bias = '0;
  logic       clear = 1'b0;
  logic       out_ready = 1'b1;

  logic       in_ready0, out_valid0, busy0;
  logic [7:0] out_data0;
  logic       in_ready4, out_valid4, busy4;
  logic [7:0] out_data4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_accum #(.TAPS(9), .ACC_W(13), .SHIFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready0), .bias(bias), .clear(clear), .out_data(out_data0),
    .out_valid(out_valid0), .out_ready(out_ready), .busy(busy0)
  );

  conv_accum #(.TAPS(9), .ACC_W(13), .SHIFT(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready4), .bias(bias), .clear(clear), .out_data(out_data4),
    .out_valid(out_valid4), .out_ready(out_ready), .busy(busy4)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " in_ready"},  int'(in_ready0),  1);
    chk({tag, " out_valid"}, int'(out_valid0), 0);
    chk({tag, " busy"},      int'(busy0),      0);
    chk({tag, " out_data"},  int'(out_data0),  0);
  endtask

  // Feeds 9 taps of value v with bias b; gaps inserts 1..3 idle cycles between taps.
  task automatic window(input string tag, input logic [7:0] b, input logic [7:0] v,
                        input bit gaps, input int exp0, input int exp4);
    for (int i = 0; i < 9; i++) begin
      bias     = b;
      in_data  = v;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      if (i < 8) begin
        if (out_valid0) chk({tag, " early out_valid"}, int'(out_valid0), 0);
        if (gaps) repeat ((i % 3) + 1) tick();
      end
    end
    chk({tag, " out_valid"}, int'(out_valid0), 1);
    chk({tag, " out_data s0"}, int'(out_data0), exp0);
    chk({tag, " out_data s4"}, int'(out_data4), exp4);
    chk({tag, " in_ready hold"}, int'(in_ready0), 0);
  endtask

  task automatic ack(input string tag);
    out_ready = 1'b1;
    tick();
    chk({tag, " out_valid after ack"}, int'(out_valid0), 0);
    chk({tag, " in_ready after ack"},  int'(in_ready0),  1);
  endtask

  initial begin
    rst = 1'b0;
    tick();
    check_reset_state("reset");
    rst = 1'b1;
    out_ready = 1'b1;

    // Basic window: 9*10 + 5 = 95
    window("basic", 8'd5, 8'd10, 1'b0, 95, 5);
    ack("basic");

    // Saturation vs. shift: 9*255 + 255 = 2550
    window("sat", 8'd255, 8'd255, 1'b0, 255, 159);
    ack("sat");

    // Back-pressure: 9*20 = 180, a tap offered during HOLD must not be consumed
    out_ready = 1'b0;
    window("bp", 8'd0, 8'd20, 1'b0, 180, 11);
    in_data  = 8'd77;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp hold out_data", int'(out_data0), 180);
      chk("bp hold in_ready", int'(in_ready0), 0);
      chk("bp hold out_valid", int'(out_valid0), 1);
    end
    in_valid = 1'b0;
    ack("bp");
    window("after bp", 8'd1, 8'd3, 1'b0, 28, 1);
    ack("after bp");

    // Gapped input gives the same result as back-to-back
    window("gaps", 8'd5, 8'd10, 1'b1, 95, 5);
    ack("gaps");

    // Clear after 4 taps, with a tap offered the same cycle
    for (int i = 0; i < 4; i++) begin
      bias = 8'd40; in_data = 8'd50; in_valid = 1'b1;
      tick();
    end
    chk("pre-clear busy", int'(busy0), 1);
    in_data = 8'd99; clear = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("clear busy", int'(busy0), 0);
    chk("clear in_ready", int'(in_ready0), 1);
    window("post clear", 8'd0, 8'd1, 1'b0, 9, 0);
    ack("post clear");

    // Clear during HOLD drops the pixel
    out_ready = 1'b0;
    window("clr hold", 8'd2, 8'd4, 1'b0, 38, 2);
    clear = 1'b1;
    out_ready = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr hold out_valid", int'(out_valid0), 0);
    chk("clr hold in_ready", int'(in_ready0), 1);
    tick();
    chk("clr hold stays idle", int'(out_valid0), 0);
    chk("clr hold busy", int'(busy0), 0);

    // Reset mid-window
    for (int i = 0; i < 5; i++) begin
      bias = 8'd9; in_data = 8'd30; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_reset_state("rst mid");
    window("after rst mid", 8'd7, 8'd11, 1'b0, 106, 6);
    ack("after rst mid");

    // Reset during HOLD
    out_ready = 1'b0;
    window("rst hold", 8'd0, 8'd6, 1'b0, 54, 3);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_reset_state("rst hold");
    out_ready = 1'b1;
    window("after rst hold", 8'd100, 8'd12, 1'b0, 208, 13);
    ack("after rst hold");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
